pipe_gen: RTL
=============

# pipe_gen

Pipe-column producer for the Flappy Bird scroller. It paces the scroll rate with a clock divider and issues one-cycle `clkP` strobes. Each strobe carries a 16-bit `newPipe` column: a pipe with a pseudo-random gap, or a blank spacer column. It drives the write side of `allPipes`, which shifts each strobed column into the 16x16 `pipefield`. It freezes when `gameover` asserts.

## Interface
- `GAP`, 4: gap height in rows; legal range 2..8.
- `SPACING`, 3: blank columns emitted between consecutive pipe columns; legal range 0..7.
- `SCROLL_DIV`, 8: clock cycles between strobes; minimum 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level input, sampled only in IDLE; leaves IDLE for RUN.
- `gameover`  in  1  level input; freezes the generator.
- `clkP`  out  1  registered one-cycle column strobe to `allPipes`.
- `newPipe`  out  16  registered column. Bit i = 1 means pipe at row i; 0 means open.
- `pipe_count`  out  8  number of pipe (non-blank) columns emitted; wraps 255→0.
- `running`  out  1  high while in RUN.

## Operation
- Reset values: state IDLE; `clkP`=0; `newPipe`=16'h0000; `pipe_count`=0; `running`=0.
- Reset values, internal: `lfsr`=8'hA5; `div_cnt`=0; `col_idx`=0; `period`=`SCROLL_DIV`.
- FSM states: IDLE, RUN, HALT.
- IDLE → RUN when `start`=1 and `gameover`=0. `start`=1 with `gameover`=1 keeps IDLE.
- RUN → HALT when `gameover`=1.
- HALT is terminal and is left only by reset. `start` is ignored in RUN and HALT.
- Divider in RUN:
  - `div_cnt` increments each cycle.
  - When `div_cnt`==`period`-1, the "tick" cycle: `div_cnt`←0, `clkP`←1, `newPipe`←next column.
  - In every other cycle and state, `clkP`←0 and `newPipe` holds.
- Column select at a tick:
  - `col_idx`==0: emit a pipe column, then advance `lfsr` and increment `pipe_count`.
  - Otherwise: emit 16'h0000.
  - Then `col_idx`←(`col_idx`==`SPACING`) ? 0 : `col_idx`+1.
- Gap position:
  - `g`=`lfsr[3:0]`.
  - `gap_pos` = `g` if `g` ≤ 16-`GAP`; otherwise `g`-(17-`GAP`).
  - Pipe column: bits `gap_pos`..`gap_pos`+`GAP`-1 are 0; all other bits are 1.
- LFSR: Fibonacci. `fb`=`lfsr[7]`^`lfsr[5]`^`lfsr[4]`^`lfsr[3]`; `lfsr`←{`lfsr[6:0]`,`fb`}. It never reaches zero.
- `gameover`=1 in a tick cycle: gameover wins. No strobe, state→HALT, `newPipe` holds its last value, and `lfsr`/`col_idx`/`pipe_count` do not change.
- `running`=1 exactly while state is RUN.
- Reset mid-operation: `reset_n` low immediately forces all reset values, including dropping an in-flight `clkP`.

## Timing
- `start` sampled high at edge E0 → RUN.
- First `clkP` is high during the cycle after edge E(`period`), i.e. `period`+1 edges after E0.
- Subsequent strobes every `period` cycles; `clkP` is never high for two consecutive cycles.
- `newPipe` changes only on the edge that raises `clkP` and is stable until the next tick.
- `pipe_count` and `lfsr` update on that same edge.
- `gameover` takes effect at the next edge: `clkP` is 0 from that edge onward.

## Configuration
- `PIPE_GEN_SPEEDUP_EN` defined:
  - When a pipe column is emitted and the new `pipe_count[2:0]`==0, `period`←max(`period`-1, `SCROLL_DIV`/2), integer floor.
  - The change applies from the following divider cycle; `div_cnt` is 0 at that point, so there is no truncated interval.
- Not defined: `period` is constant `SCROLL_DIV` and the decrement logic is absent.

## Test plan
- Reset with defaults, no `start`, 40 cycles → `clkP` never high; `newPipe`=16'h0000; `running`=0; `pipe_count`=0.
- `start` pulse at E0 → `clkP` rises after E8. Strobe 1 `newPipe`=16'hFE1F (gap_pos 5). Strobes 2–4 =16'h0000. Strobe 5 =16'hC3FF (lfsr 8'h4A, gap_pos 10). `pipe_count`=2 after strobe 5.
- `gameover` raised in a tick cycle after 3 strobes → no 4th strobe; `newPipe` holds; `running`=0. A following `start` pulse has no effect.
- `start` and `gameover` both high in IDLE → stays IDLE. Drop `gameover`, pulse `start` → normal first strobe after 9 edges.
- `reset_n` low for 1 cycle mid-interval while `clkP`=1 → `clkP` low asynchronously; all outputs at reset values; next run repeats the 16'hFE1F sequence.
- With `PIPE_GEN_SPEEDUP_EN` and `SPACING`=0 → strobe spacing is 8 cycles for pipes 1–8, then 7, …, bottoming at 4 cycles; `pipe_count` wraps 255→0 after 256 pipes.

Source files
------------

// File: rtl/pipe_gen.sv
// pipe_gen: paced pipe-column producer driving the allPipes write side.
// Define PIPE_GEN_SPEEDUP_EN to shorten the scroll period every 8 pipes.
module pipe_gen #(
    parameter int GAP        = 4,
    parameter int SPACING    = 3,
    parameter int SCROLL_DIV = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        gameover,
    output logic        clkP,
    output logic [15:0] newPipe,
    output logic [7:0]  pipe_count,
    output logic        running
);

    localparam int DW = $clog2(SCROLL_DIV + 1);
    localparam logic [DW-1:0] DIV_FULL = DW'(SCROLL_DIV);
    localparam logic [4:0] GAP_MAX = 5'(16 - GAP);
    localparam logic [3:0] GAP_WRAP = 4'(17 - GAP);
    localparam logic [2:0] COL_LAST = 3'(SPACING);
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t state, stateNext;

    logic [DW-1:0] divCnt, divCntNext;
    logic [DW-1:0] period;
    logic [2:0]    colIdx, colIdxNext;
    logic [7:0]    lfsr, lfsrNext;
    logic [7:0]    countNext;
    logic [15:0]   newPipeNext;
    logic [15:0]   pipeCol;
    logic [3:0]    gapPos;
    logic          clkPNext;
    logic          tick;
    logic          fb;

`ifdef PIPE_GEN_SPEEDUP_EN
    localparam logic [DW-1:0] DIV_MIN = DW'(SCROLL_DIV / 2);
    logic [DW-1:0] periodNext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= DIV_FULL;
        end else begin
            period <= periodNext;
        end
    end
`else
    assign period = DIV_FULL;
`endif

    // Out-of-range gap offsets fold back to the top of the column.
    always_comb begin
        if ({1'b0, lfsr[3:0]} <= GAP_MAX) begin
            gapPos = lfsr[3:0];
        end else begin
            gapPos = lfsr[3:0] - GAP_WRAP;
        end
        for (int i = 0; i < 16; i++) begin
            pipeCol[i] = !((i >= int'(gapPos)) &&
                           (i < int'(gapPos) + GAP));
        end
    end

    assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign running = (state == RUN);
    assign tick = (state == RUN) && !gameover &&
                  (divCnt == period - DW'(1));

    always_comb begin
        stateNext   = state;
        divCntNext  = divCnt;
        colIdxNext  = colIdx;
        lfsrNext    = lfsr;
        countNext   = pipe_count;
        newPipeNext = newPipe;
        clkPNext    = 1'b0;
`ifdef PIPE_GEN_SPEEDUP_EN
        periodNext  = period;
`endif
        unique case (state)
            IDLE: begin
                if (start && !gameover) begin
                    stateNext  = RUN;
                    divCntNext = '0;
                end
            end
            RUN: begin
                if (gameover) begin
                    stateNext = HALT;
                end else if (tick) begin
                    divCntNext = '0;
                    clkPNext   = 1'b1;
                    if (colIdx == 3'd0) begin
                        newPipeNext = pipeCol;
                        lfsrNext    = {lfsr[6:0], fb};
                        countNext   = pipe_count + 8'd1;
`ifdef PIPE_GEN_SPEEDUP_EN
                        if ((countNext[2:0] == 3'd0) &&
                            (period > DIV_MIN)) begin
                            periodNext = period - DW'(1);
                        end
`endif
                    end else begin
                        newPipeNext = 16'h0000;
                    end
                    if (colIdx == COL_LAST) begin
                        colIdxNext = 3'd0;
                    end else begin
                        colIdxNext = colIdx + 3'd1;
                    end
                end else begin
                    divCntNext = divCnt + DW'(1);
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            divCnt     <= '0;
            colIdx     <= 3'd0;
            lfsr       <= LFSR_SEED;
            clkP       <= 1'b0;
            newPipe    <= 16'h0000;
            pipe_count <= 8'd0;
        end else begin
            state      <= stateNext;
            divCnt     <= divCntNext;
            colIdx     <= colIdxNext;
            lfsr       <= lfsrNext;
            clkP       <= clkPNext;
            newPipe    <= newPipeNext;
            pipe_count <= countNext;
        end
    end

endmodule
